gon_collector: RTL

GON_COLLECTOR -- requirements
Module: gon_collector

---
 rtl/gon_collector.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/gon_collector.sv
// gon_collector: collects DATA_BITS words from the GON bus through a small
// input FIFO and packs PACK words per beat into global-buffer writes at
// consecutive addresses. A trailing partial beat is flushed with zeroed
// upper lanes. Optional feature macro: GON_COLLECT_STAT_EN adds a
// saturating stall_cnt output counting back-pressured write cycles.
`ifndef DATA_BITS
`define DATA_BITS 8
`endif

module gon_collector #(
  parameter int DATA_BITS  = `DATA_BITS,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_BITS  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_BITS-1:0]      in_data,
  input  logic                      start,
  input  logic [ADDR_BITS-1:0]      base_addr,
  input  logic [15:0]               total_words,
  output logic                      glb_we,
  input  logic                      glb_ready,
  output logic [ADDR_BITS-1:0]      glb_addr,
  output logic [PACK*DATA_BITS-1:0] glb_wdata,
  output logic                      done
`ifdef GON_COLLECT_STAT_EN
  ,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LANE_W = $clog2(PACK);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_BITS-1:0]  r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [15:0]           r_total;
  logic [15:0]           r_acc_cnt;
  logic [15:0]           r_pop_cnt;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [DATA_BITS-1:0]  r_pack [PACK];
  logic [LANE_W-1:0]     r_lane;
  logic                  r_pending;
  logic                  r_done;

  logic                  w_start_ok;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_beat_acc;
  logic                  w_last_pop;
  logic [LANE_W-1:0]     w_lane_sel;
  logic [DATA_BITS-1:0]  w_pop_data;

  assign w_start_ok = start && (r_state == S_IDLE);
  assign in_ready   = (r_state == S_RUN) && (r_count != FULL_CNT) && (r_acc_cnt < r_total);
  assign w_push     = in_valid && in_ready;
  assign w_beat_acc = r_pending && glb_ready;
  // A beat being accepted frees the pack register in the same cycle.
  assign w_pop      = (r_state == S_RUN) && (r_count != '0) && (!r_pending || w_beat_acc);
  assign w_lane_sel = w_beat_acc ? '0 : r_lane;
  assign w_last_pop = ((r_pop_cnt + 16'd1) == r_total);
  assign w_pop_data = r_fifo[r_rd_ptr];

  assign glb_we   = r_pending;
  assign glb_addr = r_addr;
  assign done     = r_done;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: a job ends once its last beat (full or flushed) is accepted.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = (total_words == 16'd0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (w_beat_acc && (r_pop_cnt == r_total))
          w_state_next = S_DONE;
        else if (w_pop && w_last_pop && (w_lane_sel != LAST_LANE))
          w_state_next = S_FLUSH;
      end
      S_FLUSH: if (w_beat_acc) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FIFO storage; stale entries are harmless because pointers are reset.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_start_ok) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Job bookkeeping: word totals and the write address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_total   <= '0;
      r_acc_cnt <= '0;
      r_pop_cnt <= '0;
      r_addr    <= '0;
    end else if (w_start_ok) begin
      r_total   <= total_words;
      r_acc_cnt <= '0;
      r_pop_cnt <= '0;
      r_addr    <= base_addr;
    end else begin
      if (w_push)     r_acc_cnt <= r_acc_cnt + 16'd1;
      if (w_pop)      r_pop_cnt <= r_pop_cnt + 16'd1;
      if (w_beat_acc) r_addr    <= r_addr + 1'b1;
    end
  end

  // Lane index, beat-pending flag and the registered done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane    <= '0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (w_start_ok) begin
        r_lane    <= '0;
        r_pending <= 1'b0;
      end else begin
        if (w_pop)           r_lane <= w_lane_sel + 1'b1;
        else if (w_beat_acc) r_lane <= '0;
        r_pending <= (r_pending && !w_beat_acc) ||
                     (w_pop && ((w_lane_sel == LAST_LANE) || w_last_pop));
      end
    end
  end

  for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
    // Pack lane: loads on a pop addressed to it, zeroes once its beat is taken.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                            r_pack[gi] <= '0;
      else if (w_start_ok)                                r_pack[gi] <= '0;
      else if (w_pop && (w_lane_sel == LANE_W'(gi)))      r_pack[gi] <= w_pop_data;
      else if (w_beat_acc)                                r_pack[gi] <= '0;
    end
    assign glb_wdata[gi*DATA_BITS +: DATA_BITS] = r_pack[gi];
  end

`ifdef GON_COLLECT_STAT_EN
  logic [31:0] r_stall_cnt;
  // Saturating count of cycles where a beat waits on glb_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              r_stall_cnt <= '0;
    else if (w_start_ok)                                  r_stall_cnt <= '0;
    else if (r_pending && !glb_ready && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end
  assign stall_cnt = r_stall_cnt;
`else
  // Statistics disabled: no stall counter is built.
`endif

endmodule
